pick_drop_seq: RTL
==================

Name: pick_drop_seq

Overview:
- Parametrised successor of the single-site pick/drop magnet controller.
- Decides from the current node whether to grab a block (pick) or release it (drop). Drives the electromagnet through timed engage/release phases.
- Emits one-cycle pick/drop message pulses for the message/UART block and tracks the carried block.
- Sits between the node-detection/path logic and the magnet driver and message encoder.

Parameters:
- NODE_W, 6, width of node index.
- NUM_NODES, 64, number of addressable nodes; must be <= 2**NODE_W.
- PICK_MASK, 64'h0000_000F_E000_0000, bit n = 1 marks node n as a pick site (default nodes 29-35).
- DROP_MASK, 64'h0000_0000_1FE8_4000, bit n = 1 marks node n as a drop site (default nodes 14, 19, 21-28).
- SETTLE_CYC, 25_000_000, magnet engage/release settle time in clk_50 cycles (0.5 s); must be >= 1.
- CNT_W, 8, width of delivered-block counter.

Ports:
- clk_50  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous active-high reset.
- node  input  NODE_W  current node index; sampled only on a node_detected rising edge.
- node_detected  input  1  level from the path logic; high while the bot sits on a node.
- control_mag  output  1  electromagnet enable.
- pick_message  output  1  one-cycle pulse when a pick completes.
- drop_message  output  1  one-cycle pulse when a drop completes.
- busy  output  1  high during ENGAGE or RELEASE; path logic holds the bot still while high.
- carrying  output  1  high in CARRY.
- pick_node  output  NODE_W  node of the last completed pick.
- drop_count  output  CNT_W  completed drops, saturating.
- err_drop  output  1  one-cycle pulse when an event is rejected.

Behaviour:
- Reset: all outputs 0; state EMPTY; settle counter 0; node_detected edge register 0.
- Event: a rising edge of node_detected, registered internally. The node is latched in the same cycle as the edge is detected. Evaluation happens on the next cycle.
- Out-of-range node (node >= NUM_NODES) matches neither mask and produces no event.
- States:
  - EMPTY: magnet off.
    - Latched node in PICK_MASK -> ENGAGE, control_mag=1 in the same cycle as the transition.
    - Node in DROP_MASK only -> err_drop pulse, stay in EMPTY.
  - ENGAGE: counter counts 0..SETTLE_CYC-1.
    - On terminal count -> CARRY, pick_message pulse for 1 cycle, pick_node <= latched node.
  - CARRY: control_mag=1.
    - Node in DROP_MASK -> RELEASE, control_mag=0 in the same cycle as the transition.
    - Node in PICK_MASK only -> err_drop pulse, stay in CARRY.
  - RELEASE: counter counts 0..SETTLE_CYC-1.
    - On terminal count -> EMPTY, drop_message pulse for 1 cycle, drop_count += 1, saturating at all-ones.
- Node in both masks: a pick in EMPTY, a drop in CARRY. No error.
- Events during ENGAGE/RELEASE are ignored silently; no queueing, no err_drop.
- pick_message and drop_message are never high together. Each is exactly 1 cycle wide.
- Latency:
  - node_detected rise -> control_mag change: 2 cycles.
  - Magnet change -> message pulse: SETTLE_CYC cycles.
- node_detected staying high produces only one event. It must fall and rise again before the next event.
- Reset mid-ENGAGE/RELEASE: immediate return to EMPTY, magnet off, counter cleared, no message pulse.

Optional Feature:
- Macro PICK_DROP_VISIT_LOCK_EN.
- Defined:
  - Adds a NUM_NODES-bit visited register, cleared by reset.
  - A completed pick sets the bit for that node.
  - A later pick event at a node whose bit is set gives err_drop and no ENGAGE, so each pick site is served once per run.
- Undefined: no visited register; pick sites may be re-picked without limit.

Test Plan:
- Reset, then node=30 with node_detected rising. SETTLE_CYC=4 in the bench. -> Expected: control_mag=1 two cycles after the edge, busy high for 4 cycles, then pick_message 1-cycle pulse, carrying=1, pick_node=30.
- From CARRY, node=22 event -> Expected: control_mag=0 two cycles after the edge, drop_message pulse after 4 cycles, drop_count=1, carrying=0.
- In EMPTY, node=22 event -> Expected: err_drop 1-cycle pulse, control_mag stays 0, no message. In CARRY, node=31 event -> Expected: err_drop pulse, carrying remains 1.
- node_detected held high for 20 cycles at node 30, plus a node=22 edge during ENGAGE -> Expected: exactly one pick sequence, no err_drop, no drop.
- Assert rst at cycle 2 of ENGAGE -> Expected: control_mag=0 and busy=0 asynchronously, no pick_message, drop_count unchanged at 0.
- With PICK_DROP_VISIT_LOCK_EN: pick at 30, drop at 22, pick at 30 again -> Expected: second pick gives err_drop and no control_mag. Next pick at 31 succeeds. Without the macro, the second pick at 30 succeeds.

Source files
------------

// File: rtl/pick_drop_seq.sv
// Pick/drop magnet sequencer: grabs a block at pick sites and releases it at drop sites, with timed settle phases.
// Optional macro PICK_DROP_VISIT_LOCK_EN: each pick site may be served only once per run.
module pick_drop_seq #(
  parameter int NODE_W     = 6,
  parameter int NUM_NODES  = 64,
  parameter logic [NUM_NODES-1:0] PICK_MASK = 64'h0000_000F_E000_0000,
  parameter logic [NUM_NODES-1:0] DROP_MASK = 64'h0000_0000_1FE8_4000,
  parameter int SETTLE_CYC = 25_000_000,
  parameter int CNT_W      = 8
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic [NODE_W-1:0] node,
  input  logic              node_detected,
  output logic              control_mag,
  output logic              pick_message,
  output logic              drop_message,
  output logic              busy,
  output logic              carrying,
  output logic [NODE_W-1:0] pick_node,
  output logic [CNT_W-1:0]  drop_count,
  output logic              err_drop
);

  localparam int CW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int NW1 = NODE_W + 1;
  localparam logic [CW-1:0]  LAST      = CW'(SETTLE_CYC - 1);
  localparam logic [NW1-1:0] NODES_LIM = NW1'(NUM_NODES);

  typedef enum logic [1:0] {EMPTY, ENGAGE, CARRY, RELEASE} state_t;

  state_t            state, state_nxt;
  logic              nd_q, evt, rise;
  logic [NODE_W-1:0] node_l, tgt_node, tgt_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              pick_nxt, drop_nxt, err_nxt;
  logic              in_range, is_pick, is_drop, pick_ok;

  assign rise     = node_detected & ~nd_q;
  assign in_range = {1'b0, node_l} < NODES_LIM;
  assign is_pick  = in_range && PICK_MASK[node_l];
  assign is_drop  = in_range && DROP_MASK[node_l];

`ifdef PICK_DROP_VISIT_LOCK_EN
  logic [NUM_NODES-1:0] visited;
  assign pick_ok = is_pick && !visited[node_l];

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      visited <= '0;
    end else if (pick_nxt) begin
      visited[tgt_node] <= 1'b1;
    end
  end
`else
  assign pick_ok = is_pick;
`endif

  assign control_mag = (state == ENGAGE) || (state == CARRY);
  assign busy        = (state == ENGAGE) || (state == RELEASE);
  assign carrying    = (state == CARRY);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt_node;
    pick_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      EMPTY: begin
        if (evt) begin
          if (pick_ok) begin
            state_nxt = ENGAGE;
            cnt_nxt   = '0;
            tgt_nxt   = node_l;
          end else if (is_pick || is_drop) begin
            err_nxt = 1'b1;
          end
        end
      end
      ENGAGE: begin
        if (cnt == LAST) begin
          state_nxt = CARRY;
          cnt_nxt   = '0;
          pick_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CARRY: begin
        if (evt) begin
          if (is_drop) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
          end else if (is_pick) begin
            err_nxt = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (cnt == LAST) begin
          state_nxt = EMPTY;
          cnt_nxt   = '0;
          drop_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // tgt_node is kept apart from node_l so edges seen mid-settle cannot alter the reported pick site.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      cnt          <= '0;
      nd_q         <= 1'b0;
      evt          <= 1'b0;
      node_l       <= '0;
      tgt_node     <= '0;
      pick_message <= 1'b0;
      drop_message <= 1'b0;
      err_drop     <= 1'b0;
      pick_node    <= '0;
      drop_count   <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      nd_q         <= node_detected;
      evt          <= rise;
      tgt_node     <= tgt_nxt;
      pick_message <= pick_nxt;
      drop_message <= drop_nxt;
      err_drop     <= err_nxt;
      if (rise) begin
        node_l <= node;
      end
      if (pick_nxt) begin
        pick_node <= tgt_node;
      end
      if (drop_nxt && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
